// File: rtl/junsigned_seq_divider.sv
// junsigned_seq_divider
//   Sequential unsigned restoring divider. A 2W-bit dividend is divided by a
//   W-bit divisor, giving one quotient bit per clock. The results satisfy
//   dividend = quotient*divisor + remainder.
//
//   Optional build macro: DIV_ERR_FAST_EN
//     defined   - operations flagged as errors (divide-by-zero or quotient
//                 overflow) skip the CALC phase. done follows the start edge
//                 after one cycle.
//     undefined - every operation walks all W CALC cycles, so the latency is
//                 always W+1 cycles.
//
// Handshake (start / busy / done):
//   start is sampled only while the FSM is IDLE. On that edge the operands are
//   captured and busy rises. busy stays high through the CALC cycles. done is
//   high for exactly one cycle (the DONE state). In that cycle busy is low and
//   quotient/remainder/err already show the new values. start while busy or
//   during DONE is dropped, not queued. A start in the IDLE cycle right after
//   done is accepted. quotient, remainder and err only change on the edge that
//   enters DONE, and they hold their values at all other times.

module junsigned_seq_divider #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operation context captured on the start edge
  logic [W-1:0]  dvd_lo;   // low half of the dividend, consumed bit by bit
  logic [W-1:0]  dvs_r;    // captured divisor
  logic [W:0]    p_r;      // partial remainder, one bit wider than divisor
  logic [W-1:0]  q_acc;    // quotient bits collected so far, MSB first
  logic [IW-1:0] idx;      // index of the dividend bit brought in next
  logic          err_r;    // operation was flagged as an error at start

  // Combinational step signals
  logic [W:0]    p_shift;
  logic [W:0]    p_step;
  logic          q_bit;
  logic          last_step;
  logic          op_err;
  logic          accept;

  // Error classification of the operands currently on the inputs
  always_comb begin
    op_err = 1'b0;
    if ((divisor == '0) || (dividend[2*W-1:W] >= divisor)) begin
      op_err = 1'b1;
    end
  end

  // One restoring step: shift in the next dividend bit, then trial-subtract
  always_comb begin
    p_shift   = {p_r[W-1:0], dvd_lo[idx]};
    p_step    = p_shift;
    q_bit     = 1'b0;
    last_step = (idx == '0);
    if (p_shift >= {1'b0, dvs_r}) begin
      p_step = p_shift - {1'b0, dvs_r};
      q_bit  = 1'b1;
    end
  end

  assign accept = (state == S_IDLE) && start;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ERR_FAST_EN
          state_next = op_err ? S_DONE : S_CALC;
`else
          state_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_lo <= '0;
      dvs_r  <= '0;
      p_r    <= '0;
      q_acc  <= '0;
      idx    <= '0;
      err_r  <= 1'b0;
    end else if (accept) begin
      dvd_lo <= dividend[W-1:0];
      dvs_r  <= divisor;
      p_r    <= {1'b0, dividend[2*W-1:W]};
      q_acc  <= '0;
      idx    <= IW'(W - 1);
      err_r  <= op_err;
    end else if (state == S_CALC) begin
      p_r    <= p_step;
      q_acc  <= {q_acc[W-2:0], q_bit};
      idx    <= idx - 1'b1;
    end
  end

  // Result registers: written only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      err       <= 1'b0;
    end else begin
`ifdef DIV_ERR_FAST_EN
      if (accept && op_err) begin
        quotient  <= '1;
        remainder <= dividend[W-1:0];
        err       <= 1'b1;
      end
`endif
      if ((state == S_CALC) && last_step) begin
        err <= err_r;
        if (err_r) begin
          quotient  <= '1;
          remainder <= dvd_lo;
        end else begin
          quotient  <= {q_acc[W-2:0], q_bit};
          remainder <= p_step[W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_junsigned_seq_divider.sv
// tb_junsigned_seq_divider
//   Directed and random operations on the W=4 divider. The reference model
//   uses plain integer division and modulo.

module tb_junsigned_seq_divider;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           err;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {err, quotient, remainder}
  logic [2*W:0] exp_q[$];

  junsigned_seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [2*W:0] model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] hi;
    int unsigned  ai, bi;
    hi = a[2*W-1:W];
    ai = a;
    bi = b;
    if ((b == 0) || (hi >= b)) return {1'b1, {W{1'b1}}, a[W-1:0]};
    return {1'b0, W'(ai / bi), W'(ai % bi)};
  endfunction

  function automatic int model_lat(input logic [2*W:0] e);
`ifdef DIV_ERR_FAST_EN
    if (e[2*W]) return 1;
`endif
    return W + 1;
  endfunction

  function automatic int model_busy(input logic [2*W:0] e);
`ifdef DIV_ERR_FAST_EN
    if (e[2*W]) return 0;
`endif
    return W;
  endfunction

  // driver: one operation. Returns in the IDLE cycle right after done.
  task automatic drive_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cyc, output bit stable_ok,
                          output logic [2*W:0] got);
    logic [2*W:0] prev;
    @(negedge clk);
    prev     = {err, quotient, remainder};
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    lat       = 1;
    busy_cyc  = 0;
    stable_ok = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      if ({err, quotient, remainder} !== prev) stable_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    got = {err, quotient, remainder};
    @(posedge clk); #1;
  endtask

  // operation with scoreboard and inline checks
  task automatic test_op(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b);
    int lat, bc;
    bit st;
    logic [2*W:0] got, e;
    exp_q.push_back(model(a, b));
    drive_op(a, b, lat, bc, st, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL %s result a=%0d b=%0d: got err/q/r=%0d/%0d/%0d want %0d/%0d/%0d",
                            name, a, b, got[2*W], got[2*W-1:W], got[W-1:0], e[2*W], e[2*W-1:W], e[W-1:0]);
    else n_pass++;
    n_checks++;
    if (lat !== model_lat(e)) $display("FAIL %s latency a=%0d b=%0d: got %0d want %0d", name, a, b, lat, model_lat(e));
    else n_pass++;
    n_checks++;
    if (bc !== model_busy(e)) $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, model_busy(e));
    else n_pass++;
    n_checks++;
    if (st !== 1'b1) $display("FAIL %s outputs_stable: got 0 want 1", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err, quotient, remainder} !== '0)
      $display("FAIL reset_outputs: got %b want 0", {busy, done, err, quotient, remainder});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    test_op("t1_225_15", 8'd225, 4'd15);
    test_op("t2_100_7", 8'd100, 4'd7);
    test_op("t2_0_1", 8'd0, 4'd1);
    test_op("t2_255_1_ovf", 8'd255, 4'd1);
    test_op("t2_15_1", 8'd15, 4'd1);
  endtask

  task automatic test_errors();
    test_op("t3_div0", 8'd9, 4'd0);
    test_op("t4_ovf_240_15", 8'd240, 4'd15);
    test_op("t4_239_15", 8'd239, 4'd15);
    test_op("t3_div0_big", 8'd255, 4'd0);
  endtask

  task automatic test_ignore_start();
    int n_done, first_lat;
    logic [2*W:0] got;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; first_lat = 0; got = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done) begin
        n_done++;
        if (first_lat == 0) begin
          first_lat = cyc;
          got = {err, quotient, remainder};
        end
      end
      if (cyc == 1) begin
        start = 1'b1; dividend = 8'd225; divisor = 4'd15;
      end
      if (cyc == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_done !== 1) $display("FAIL busy_start_done_count: got %0d want 1", n_done);
    else n_pass++;
    n_checks++;
    if (first_lat !== W + 1) $display("FAIL busy_start_latency: got %0d want %0d", first_lat, W + 1);
    else n_pass++;
    n_checks++;
    if (got !== model(8'd100, 4'd7)) $display("FAIL busy_start_result: got %h want %h", got, model(8'd100, 4'd7));
    else n_pass++;
  endtask

  task automatic test_start_in_done();
    int lat, busy_seen;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // held over the DONE-cycle edge only
    start = 1'b1; dividend = 8'd225; divisor = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy || done) busy_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy_seen !== 0) $display("FAIL done_cycle_start_ignored: got %0d active cycles want 0", busy_seen);
    else n_pass++;
    n_checks++;
    if ({err, quotient, remainder} !== model(8'd100, 4'd7))
      $display("FAIL done_cycle_result_held: got %h want %h", {err, quotient, remainder}, model(8'd100, 4'd7));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // drive_op returns in the IDLE cycle after done, so these starts are adjacent
    test_op("b2b_a", 8'd100, 4'd7);
    test_op("b2b_b", 8'd225, 4'd15);
    test_op("b2b_c", 8'd9, 4'd0);
    test_op("b2b_d", 8'd50, 4'd5);
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    @(negedge clk);
    dividend = 8'd225; divisor = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, quotient, remainder} !== '0)
      $display("FAIL midop_reset_outputs: got %b want 0", {busy, done, err, quotient, remainder});
    else n_pass++;
    n_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL midop_reset_no_done: got %0d active cycles want 0", n_done);
    else n_pass++;
    test_op("t6_50_5", 8'd50, 4'd5);
  endtask

  task automatic test_random();
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 3) begin
        a = 8'($urandom_range(0, 255));
        b = 4'($urandom_range(0, 15));
      end else begin
        b = 4'($urandom_range(1, 15));
        a = 8'($urandom_range(0, int'(b) * 16 - 1));
      end
      test_op("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_ignore_start();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
